// File: rtl/branch_resolve_unit.sv
// Two-stage valid/ready branch condition evaluator with misprediction flagging
// and saturating statistics counters.
module branch_resolve_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   input  logic [3:0]       func_code,
   input  logic             pred_taken,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic             out_mispredict,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   typedef enum logic [3:0] {
      F_EQZ    = 4'h0,
      F_LTZ    = 4'h1,
      F_GTZ    = 4'h2,
      F_EQ     = 4'h3,
      F_NE     = 4'h4,
      F_LT     = 4'h5,
      F_GE     = 4'h6,
      F_LTU    = 4'h7,
      F_GEU    = 4'h8,
      F_NEZ    = 4'h9,
      F_ALWAYS = 4'hA
   } func_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_reg1_q, s1_reg1_d;
   logic [WIDTH-1:0] s1_reg2_q, s1_reg2_d;
   func_e            s1_func_q, s1_func_d;
   logic             s1_pred_q, s1_pred_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_taken_q, s2_taken_d;
   logic             s2_mis_q, s2_mis_d;
   logic             s2_ill_q, s2_ill_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   logic s1_load, s2_load, out_fire;
   logic cmp_taken, cmp_illegal;

   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign s1_load  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready && !flush;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cmp_taken   = 1'b0;
      cmp_illegal = 1'b0;
      case (s1_func_q)
         F_EQZ:    cmp_taken = (s1_reg1_q == '0);
         F_LTZ:    cmp_taken = s1_reg1_q[WIDTH-1];
         F_GTZ:    cmp_taken = !s1_reg1_q[WIDTH-1] && (s1_reg1_q != '0);
         F_EQ:     cmp_taken = (s1_reg1_q == s1_reg2_q);
         F_NE:     cmp_taken = (s1_reg1_q != s1_reg2_q);
         F_LT:     cmp_taken = ($signed(s1_reg1_q) <  $signed(s1_reg2_q));
         F_GE:     cmp_taken = ($signed(s1_reg1_q) >= $signed(s1_reg2_q));
         F_LTU:    cmp_taken = (s1_reg1_q <  s1_reg2_q);
         F_GEU:    cmp_taken = (s1_reg1_q >= s1_reg2_q);
         F_NEZ:    cmp_taken = (s1_reg1_q != '0);
         F_ALWAYS: cmp_taken = 1'b1;
         default:  cmp_illegal = 1'b1;
      endcase
   end

   always_comb begin
      s1_reg1_d = s1_reg1_q;
      s1_reg2_d = s1_reg2_q;
      s1_func_d = s1_func_q;
      s1_pred_d = s1_pred_q;
      s1_tag_d  = s1_tag_q;
      if (s1_load) begin
         s1_reg1_d = reg1;
         s1_reg2_d = reg2;
         s1_func_d = func_e'(func_code);
         s1_pred_d = pred_taken;
         s1_tag_d  = in_tag;
      end

      s2_taken_d = s2_taken_q;
      s2_mis_d   = s2_mis_q;
      s2_ill_d   = s2_ill_q;
      s2_tag_d   = s2_tag_q;
      if (s2_load) begin
         s2_taken_d = cmp_taken;
         s2_mis_d   = cmp_taken ^ s1_pred_q;
         s2_ill_d   = cmp_illegal;
         s2_tag_d   = s1_tag_q;
      end

      // Flush kills both stages, including any request offered this cycle.
      if (flush)        s1_valid_d = 1'b0;
      else if (s1_load) s1_valid_d = 1'b1;
      else if (s2_load) s1_valid_d = 1'b0;
      else              s1_valid_d = s1_valid_q;

      if (flush)          s2_valid_d = 1'b0;
      else if (s2_load)   s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
      else                s2_valid_d = s2_valid_q;

      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (cnt_clr) begin
         br_cnt_d  = '0;
         mis_cnt_d = '0;
      end else if (out_fire) begin
         if (br_cnt_q != CNT_MAX)              br_cnt_d  = br_cnt_q + 1'b1;
         if (s2_mis_q && mis_cnt_q != CNT_MAX) mis_cnt_d = mis_cnt_q + 1'b1;
      end
   end

   // NOTE: stage-1 payload is only read while s1_valid_q is set, so it carries no reset.
   always_ff @(posedge clk) begin
      s1_reg1_q <= s1_reg1_d;
      s1_reg2_q <= s1_reg2_d;
      s1_func_q <= s1_func_d;
      s1_pred_q <= s1_pred_d;
      s1_tag_q  <= s1_tag_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_taken_q <= 1'b0;
         s2_mis_q   <= 1'b0;
         s2_ill_q   <= 1'b0;
         s2_tag_q   <= '0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_taken_q <= s2_taken_d;
         s2_mis_q   <= s2_mis_d;
         s2_ill_q   <= s2_ill_d;
         s2_tag_q   <= s2_tag_d;
         br_cnt_q   <= br_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   assign out_valid        = s2_valid_q;
   assign out_taken        = s2_taken_q;
   assign out_mispredict   = s2_mis_q;
   assign out_illegal      = s2_ill_q;
   assign out_tag          = s2_tag_q;
   assign branch_count     = br_cnt_q;
   assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit; a second instance with
// 2-bit counters shares the stimulus to exercise saturation.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] reg1, reg2;
   logic [3:0]  func_code;
   logic        pred_taken;
   logic [3:0]  in_tag;
   logic        flush;
   logic        out_ready;
   logic        cnt_clr;

   logic        in_ready, out_valid, out_taken, out_mispredict, out_illegal;
   logic [3:0]  out_tag;
   logic [15:0] branch_count, mispredict_count;

   logic        s_in_ready, s_out_valid, s_out_taken, s_out_mispredict, s_out_illegal;
   logic [3:0]  s_out_tag;
   logic [1:0]  s_branch_count, s_mispredict_count;

   always #5 clk = ~clk;

   branch_resolve_unit u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .reg1(reg1), .reg2(reg2), .func_code(func_code), .pred_taken(pred_taken),
      .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
      .out_tag(out_tag), .cnt_clr(cnt_clr), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   branch_resolve_unit #(.CNT_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .reg1(reg1), .reg2(reg2), .func_code(func_code), .pred_taken(pred_taken),
      .in_tag(in_tag), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_taken(s_out_taken), .out_mispredict(s_out_mispredict), .out_illegal(s_out_illegal),
      .out_tag(s_out_tag), .cnt_clr(cnt_clr), .branch_count(s_branch_count),
      .mispredict_count(s_mispredict_count)
   );

   typedef struct {
      logic [3:0] tag;
      bit         taken;
      bit         mis;
      bit         ill;
      int         acc_edge;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   br_n = 0;
   int   mis_n = 0;
   bit   last_acc;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   // Branch condition from plain integer arithmetic on the operand values.
   function automatic bit ref_taken(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint ua = a;
      longint ub = b;
      longint sa = a;
      longint sb = b;
      if (ua >= (longint'(1) << 31)) sa = ua - (longint'(1) << 32);
      if (ub >= (longint'(1) << 31)) sb = ub - (longint'(1) << 32);
      case (f)
         4'd0:    return sa == 0;
         4'd1:    return sa < 0;
         4'd2:    return sa > 0;
         4'd3:    return ua == ub;
         4'd4:    return ua != ub;
         4'd5:    return sa < sb;
         4'd6:    return sa >= sb;
         4'd7:    return ua < ub;
         4'd8:    return ua >= ub;
         4'd9:    return ua != 0;
         4'd10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      bit   exp_rdy, exp_ov, acc, hs;
      exp_t e, popped;
      #1;
      exp_ov  = (q.size() > 0) && (edge_cnt - q[0].acc_edge >= 1);
      exp_rdy = !(q.size() == 2 && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_ov);
      check("sat_out_valid", s_out_valid, exp_ov);
      if (exp_ov) begin
         check("out_tag", out_tag, q[0].tag);
         check("out_taken", out_taken, q[0].taken);
         check("out_mispredict", out_mispredict, q[0].mis);
         check("out_illegal", out_illegal, q[0].ill);
      end
      check("branch_count", branch_count, sat(br_n, 65535));
      check("mispredict_count", mispredict_count, sat(mis_n, 65535));
      check("sat_branch_count", s_branch_count, sat(br_n, 3));
      check("sat_mispredict_count", s_mispredict_count, sat(mis_n, 3));

      acc      = in_valid && exp_rdy && !flush;
      hs       = exp_ov && out_ready && !flush;
      last_acc = acc;
      e.tag    = in_tag;
      e.ill    = (func_code > 4'd10);
      e.taken  = ref_taken(func_code, reg1, reg2);
      e.mis    = e.taken ^ pred_taken;

      @(posedge clk);
      edge_cnt++;
      popped = '{tag: 4'd0, taken: 1'b0, mis: 1'b0, ill: 1'b0, acc_edge: 0};
      if (flush) begin
         q.delete();
      end else begin
         if (hs) popped = q.pop_front();
         if (acc) begin
            e.acc_edge = edge_cnt;
            q.push_back(e);
         end
      end
      if (cnt_clr) begin
         br_n  = 0;
         mis_n = 0;
      end else if (hs) begin
         br_n++;
         if (popped.mis) mis_n++;
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic p, input logic [3:0] t);
      in_valid   = 1'b1;
      func_code  = f;
      reg1       = a;
      reg2       = b;
      pred_taken = p;
      in_tag     = t;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_acc) break;
      end
      if (!last_acc) check("send_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      q.delete();
      br_n  = 0;
      mis_n = 0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_taken", out_taken, 0);
      check("rst_out_mispredict", out_mispredict, 0);
      check("rst_out_illegal", out_illegal, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_branch_count", branch_count, 0);
      check("rst_mispredict_count", mispredict_count, 0);
      check("rst_sat_branch_count", s_branch_count, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      in_valid = 0; reg1 = 0; reg2 = 0; func_code = 0; pred_taken = 0;
      in_tag = 0; flush = 0; out_ready = 1; cnt_clr = 0;
      do_reset();

      // First branch: reg1 == 0, predicted not-taken -> mispredict.
      send(4'h0, 32'd0, 32'd0, 1'b0, 4'd1);
      drain();

      // Signed versus unsigned compare of the same operands.
      send(4'h5, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd2);
      send(4'h7, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd3);
      send(4'h1, 32'h8000_0000, 32'd0, 1'b1, 4'd4);
      send(4'h2, 32'h8000_0000, 32'd0, 1'b1, 4'd5);
      drain();

      // Eight back-to-back requests with the consumer always ready.
      for (int i = 0; i < 8; i++) send(4'($urandom_range(0, 10)), $urandom, $urandom, 1'($urandom), 4'(i));
      drain();

      // Stall: two accepts fill the pipe, the third waits for out_ready.
      out_ready = 1'b0;
      send(4'h3, 32'd7, 32'd7, 1'b1, 4'd8);
      send(4'h4, 32'd7, 32'd7, 1'b1, 4'd9);
      in_valid = 1'b1; func_code = 4'hA; in_tag = 4'd10;
      repeat (3) tick();
      out_ready = 1'b1;
      send(4'hA, 32'd0, 32'd0, 1'b0, 4'd10);
      drain();

      // Flush with both stages full; the offered and presented items are dropped.
      out_ready = 1'b0;
      send(4'h6, 32'd3, 32'd5, 1'b0, 4'd11);
      send(4'h8, 32'd3, 32'd5, 1'b0, 4'd12);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_tag = 4'd13;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tick();
      send(4'h9, 32'd1, 32'd0, 1'b1, 4'd14);
      drain();

      // Saturation of the 2-bit counters, clear, then an illegal code.
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(4'h0, 32'd5, 32'd0, 1'b1, 4'(i));
      drain();
      repeat (2) tick();
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      send(4'hC, 32'd0, 32'd0, 1'b0, 4'd15);
      drain();
      send(4'hF, 32'd0, 32'd0, 1'b1, 4'd6);
      drain();

      // Random traffic with occasional flush and clear.
      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         func_code  = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       begin reg1 = $urandom; reg2 = reg1; end
            1:       begin reg1 = 32'd0; reg2 = $urandom; end
            default: begin reg1 = $urandom; reg2 = $urandom; end
         endcase
         pred_taken = 1'($urandom);
         in_tag     = 4'($urandom);
         out_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 49) == 0);
         cnt_clr    = ($urandom_range(0, 49) == 0);
         tick();
      end
      flush = 1'b0; cnt_clr = 1'b0;
      drain();

      // Reset in the middle of a stalled stream discards everything.
      out_ready = 1'b0;
      send(4'hA, 32'd0, 32'd0, 1'b0, 4'd1);
      send(4'hA, 32'd0, 32'd0, 1'b1, 4'd2);
      do_reset();
      drain();
      send(4'h3, 32'd9, 32'd9, 1'b1, 4'd3);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the single-operand branch comparator: evaluates a branch condition on one or two register operands, selected by a function code, and reports taken/not-taken plus misprediction against a supplied prediction. Sits between register read and the fetch redirect logic. A two-stage valid/ready pipeline carries an opaque tag. Saturating counters track resolved branches and mispredictions.

## Interface
- WIDTH, 32, operand width (two's complement for signed compares)
- TAG_W, 4, width of pass-through tag
- CNT_W, 16, width of statistics counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request this cycle
- reg1, reg2  in  WIDTH each  operands
- func_code  in  4  condition select
- pred_taken  in  1  front-end prediction
- in_tag  in  TAG_W  request identifier
- flush  in  1  synchronous kill of all in-flight requests
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken, out_mispredict, out_illegal  out  1 each  result fields
- out_tag  out  TAG_W  tag of result
- cnt_clr  in  1  synchronous clear of counters
- branch_count, mispredict_count  out  CNT_W each  statistics

## Operation
- Function codes: 0000 reg1==0; 0001 reg1<0 signed; 0010 reg1>0 signed; 0011 reg1==reg2; 0100 reg1!=reg2; 0101 reg1<reg2 signed; 0110 reg1>=reg2 signed; 0111 reg1<reg2 unsigned; 1000 reg1>=reg2 unsigned; 1001 reg1!=0; 1010 always taken.
- Codes 1011-1111: out_taken=0, out_illegal=1, out_mispredict=pred_taken.
- out_mispredict = out_taken XOR pred_taken for legal codes.
- Stage 1 (S1) registers operands, func_code, pred_taken, tag on accept (in_valid && in_ready).
- Stage 2 (S2) registers compare result from S1; S2 drives all out_* signals directly from flops.
- Advance rule: S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when in_valid and (S1 empty or S1 advancing).
- in_ready = !S1_valid || !S2_valid || out_ready (combinational path out_ready -> in_ready permitted).
- Payload held stable while out_valid && !out_ready.
- flush: next cycle S1_valid=S2_valid=0; request offered in flush cycle is dropped; result presented in flush cycle is not counted even if out_ready=1.
- Counters: on output handshake (out_valid && out_ready && !flush), branch_count += 1; mispredict_count += 1 if out_mispredict. Illegal results count in both per their flags. Both saturate at 2^CNT_W-1.
- cnt_clr: counters 0 next cycle; a coincident handshake is not counted (clear wins).

## Timing
- Reset: in_ready=1, out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_tag=0, both counters 0; pipeline flags cleared immediately (async).
- Latency: accept at edge N -> out_valid high after edge N+1 (two edges).
- Throughput: one result per cycle with out_ready held high.
- Full: both stages valid and out_ready=0 -> in_ready=0; no request lost or duplicated.
- Simultaneous flush and reset: reset dominates. Reset mid-stream discards all in-flight results.
- Counter wrap: never; saturated counter holds until cnt_clr or reset.

## Test plan
- Reset then func 0000, reg1=0, pred_taken=0 -> two edges later out_valid=1, out_taken=1, out_mispredict=1, mispredict_count=1 after handshake.
- func 0101 reg1=0xFFFFFFFF, reg2=1 -> taken=1; func 0111 same operands -> taken=0 (signed vs unsigned).
- Back-to-back 8 requests, tags 0-7, out_ready=1 -> 8 results in order, one per cycle, branch_count=8.
- Hold out_ready=0 with 3 requests offered -> in_ready drops after 2 accepts; outputs stable; release -> tags emerge in order, none lost.
- flush while both stages full -> out_valid=0 next cycle, counters unchanged, new request accepted following cycle.
- CNT_W=2, 5 mispredicted branches -> both counters saturate at 3; cnt_clr -> 0; func 1100 -> out_illegal=1, taken=0.
